// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
// Op-codes follow funct3; the state type is shared by the FSM and the bench.
package mdu_pkg;

  localparam int unsigned MDU_XLEN = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE,
    MDU_CALC,
    MDU_DONE
  } mdu_state_e;

  function automatic logic mdu_is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/mdu_operand_prep.sv
// Combinational operand conditioning: magnitudes, sign-fix flags and the
// divide-by-zero / signed-overflow shortcuts that skip the iteration.
module mdu_operand_prep
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] mag_a_o,
  output logic [XLEN-1:0] mag_b_o,
  output logic            neg_res_o,
  output logic            neg_rem_o,
  output logic            special_o,
  output logic [XLEN-1:0] special_res_o
);

  localparam logic [XLEN-1:0] MostNeg = {1'b1, {(XLEN-1){1'b0}}};

  logic signed_a, signed_b;
  logic sign_a, sign_b;
  logic div_zero, div_ovf;

  always_comb begin
    signed_a = 1'b0;
    signed_b = 1'b0;
    case (op_i)
      MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: begin
        signed_a = 1'b1;
        signed_b = 1'b1;
      end
      MDU_MULHSU: signed_a = 1'b1;
      default: ;
    endcase
  end

  assign sign_a    = signed_a & a_i[XLEN-1];
  assign sign_b    = signed_b & b_i[XLEN-1];
  assign mag_a_o   = sign_a ? -a_i : a_i;
  assign mag_b_o   = sign_b ? -b_i : b_i;
  assign neg_res_o = sign_a ^ sign_b;
  assign neg_rem_o = (op_i == MDU_REM) & sign_a;

  assign div_zero  = mdu_is_div(op_i) && (b_i == '0);
  assign div_ovf   = ((op_i == MDU_DIV) || (op_i == MDU_REM)) &&
                     (a_i == MostNeg) && (b_i == '1);
  assign special_o = div_zero | div_ovf;

  // op_i[1] separates the remainder ops from the quotient ops.
  always_comb begin
    special_res_o = '0;
    if (div_zero)     special_res_o = op_i[1] ? a_i : '1;
    else if (div_ovf) special_res_o = op_i[1] ? '0 : a_i;
  end

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide
// step per CALC cycle, start/done handshake, registered result.
module mdu
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = MDU_XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic [2:0]      MDUControl,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] MDUResult,
  output logic            zero
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;

  mdu_state_e        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [2:0]        op_q, op_d;
  logic              neg_res_q, neg_res_d;
  logic              neg_rem_q, neg_rem_d;

  logic [XLEN-1:0]   mag_a, mag_b, special_res;
  logic              neg_res, neg_rem, special;

  mdu_operand_prep #(
    .XLEN(XLEN)
  ) u_prep (
    .op_i          (MDUControl),
    .a_i           (SrcA),
    .b_i           (SrcB),
    .mag_a_o       (mag_a),
    .mag_b_o       (mag_b),
    .neg_res_o     (neg_res),
    .neg_rem_o     (neg_rem),
    .special_o     (special),
    .special_res_o (special_res)
  );

  // acc_q is the product register for multiplies and {remainder, quotient}
  // for divides; opnd_q is the multiplicand or the divisor respectively.
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next, step, prod;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0],  acc_q[XLEN-2:0], 1'b1};
    step      = mdu_is_div(op_q) ? div_next : mul_next;
    prod      = neg_res_q ? -mul_next : mul_next;
    quo       = div_next[XLEN-1:0];
    rem       = div_next[2*XLEN-1:XLEN];
    if (!op_q[2])     final_res = (op_q == MDU_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    else if (op_q[1]) final_res = neg_rem_q ? -rem : rem;
    else              final_res = neg_res_q ? -quo : quo;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    unique case (state_q)
      MDU_CALC: begin
        acc_d = step;
        if (cnt_q == '0) begin
          state_d  = MDU_DONE;
          result_d = final_res;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        if (start) begin
          op_d      = MDUControl;
          neg_res_d = neg_res;
          neg_rem_d = neg_rem;
          opnd_d    = mdu_is_div(MDUControl) ? mag_b : mag_a;
          acc_d     = {{XLEN{1'b0}}, (mdu_is_div(MDUControl) ? mag_a : mag_b)};
          if (special) begin
            state_d  = MDU_DONE;
            result_d = special_res;
          end else begin
            state_d = MDU_CALC;
            cnt_d   = CW'(XLEN - 1);
          end
        end else begin
          state_d = MDU_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= MDU_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy      = (state_q == MDU_CALC);
  assign done      = (state_q == MDU_DONE);
  assign MDUResult = result_q;
  assign zero      = (result_q == '0);

endmodule

// File: tb/tb_mdu.sv
// Directed and random checks of mdu against a 64-bit reference model,
// using a result scoreboard filled at issue and drained at done.
module tb_mdu;
  import mdu_pkg::*;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic [2:0]  MDUControl = '0;
  logic        busy, done, zero;
  logic [31:0] MDUResult;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [31:0] sb[$];

  mdu #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .MDUControl (MDUControl),
    .busy       (busy),
    .done       (done),
    .MDUResult  (MDUResult),
    .zero       (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb64, ua, ub, p;
    sa   = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    ua   = {32'b0, a};
    ub   = {32'b0, b};
    case (op)
      MDU_MUL:    begin p = sa * sb64; return p[31:0];  end
      MDU_MULH:   begin p = sa * sb64; return p[63:32]; end
      MDU_MULHSU: begin p = sa * ub;   return p[63:32]; end
      MDU_MULHU:  begin p = ua * ub;   return p[63:32]; end
      MDU_DIV:    begin if (b == 0) return '1; p = sa / sb64; return p[31:0]; end
      MDU_DIVU:   begin if (b == 0) return '1; p = ua / ub;   return p[31:0]; end
      MDU_REM:    begin if (b == 0) return a;  p = sa % sb64; return p[31:0]; end
      default:    begin if (b == 0) return a;  p = ua % ub;   return p[31:0]; end
    endcase
  endfunction

  // Called at a negedge; drives a one-cycle request and records its result.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    start      = 1'b1;
    MDUControl = op;
    SrcA       = a;
    SrcB       = b;
    sb.push_back(exp);
  endtask

  task automatic wait_done(input int unsigned lat0, output int unsigned lat,
                           output int unsigned busy_n);
    lat    = lat0;
    busy_n = 0;
    while (done !== 1'b1 && lat < 60) begin
      busy_n += (busy === 1'b1) ? 1 : 0;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire(input string tag);
    logic [31:0] exp;
    check({tag, " done"}, {31'b0, done}, 32'd1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed empty scoreboard expected a pending result", tag);
    end else begin
      exp = sb.pop_front();
      check({tag, " result"}, MDUResult, exp);
      check({tag, " zero"}, {31'b0, zero}, {31'b0, (exp == 0)});
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int unsigned exp_lat);
    int unsigned lat, bn;
    @(negedge clk);
    issue(op, a, b, exp);
    @(negedge clk);
    start = 1'b0;
    SrcA  = $urandom;
    SrcB  = $urandom;
    wait_done(1, lat, bn);
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    check({tag, " busy cycles"}, 32'(bn), 32'(exp_lat - 1));
    retire(tag);
    @(negedge clk);
    check({tag, " done pulse"}, {31'b0, done}, 32'd0);
  endtask

  initial begin
    int unsigned lat, bn, el;
    logic [2:0]  op;
    logic [31:0] a, b;

    repeat (3) @(negedge clk);
    check("reset busy", {31'b0, busy}, 32'd0);
    check("reset done", {31'b0, done}, 32'd0);
    check("reset result", MDUResult, 32'd0);
    check("reset zero", {31'b0, zero}, 32'd1);
    rst_n = 1'b1;

    run_op("MUL 7*-3", MDU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    run_op("MULH", MDU_MULH, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    run_op("MULHSU", MDU_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("MULHU", MDU_MULHU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 33);
    run_op("DIV -7/2", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2", MDU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("DIVU 50/10", MDU_DIVU, 32'd50, 32'd10, 32'd5, 33);
    run_op("REMU 10/50", MDU_REMU, 32'd10, 32'd50, 32'd10, 33);
    run_op("DIVU 10/0", MDU_DIVU, 32'd10, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("REM 10/0", MDU_REM, 32'd10, 32'd0, 32'd10, 1);
    run_op("DIV ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf", MDU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("REM 5/5", MDU_REM, 32'd5, 32'd5, 32'd0, 33);

    for (int i = 0; i < 10; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = (i % 2 == 0) ? 32'($urandom_range(0, 5000)) : $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(1, 40)) : $urandom;
      if (i == 7) b = '0;
      el = (op[2] && (b == 0 || (a == 32'h8000_0000 && b == '1 && !op[0]))) ? 1 : 33;
      run_op("random", op, a, b, model(op, a, b), el);
    end

    // start pulsed mid-CALC must not disturb the running operation
    @(negedge clk);
    issue(MDU_MUL, 32'd123, 32'd456, 32'd56088);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1; MDUControl = MDU_DIVU; SrcA = 32'd99; SrcB = 32'd3;
    @(negedge clk);
    start = 1'b0;
    wait_done(7, lat, bn);
    check("ignored start latency", 32'(lat), 32'd33);
    retire("ignored start");
    @(negedge clk);
    check("ignored start idle", {31'b0, busy}, 32'd0);

    // start held in DONE chains straight into the next CALC
    @(negedge clk);
    issue(MDU_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, model(MDU_MULHU, '1, '1));
    @(negedge clk);
    start = 1'b0;
    wait_done(1, lat, bn);
    issue(MDU_DIVU, 32'd50, 32'd10, 32'd5);
    retire("b2b first");
    @(negedge clk);
    start = 1'b0;
    check("b2b busy", {31'b0, busy}, 32'd1);
    check("b2b held result", MDUResult, 32'hFFFF_FFFE);
    wait_done(1, lat, bn);
    check("b2b latency", 32'(lat), 32'd33);
    retire("b2b second");

    // asynchronous reset at CALC cycle 10
    @(negedge clk);
    issue(MDU_MUL, 32'd1000, 32'd1000, 32'd1_000_000);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre-reset busy", {31'b0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", {31'b0, busy}, 32'd0);
    check("async reset done", {31'b0, done}, 32'd0);
    check("async reset result", MDUResult, 32'd0);
    check("async reset zero", {31'b0, zero}, 32'd1);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    run_op("MUL after reset", MDU_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
